// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART packet deframer
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAY,
        ST_CHK,
        ST_SEND
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam int         CHK_W         = 8;

endpackage

// File: rtl/uart_pkt_rx_if.sv
// rtl/uart_pkt_rx_if.sv - UART FIFO pop side plus validated payload byte stream
interface uart_pkt_rx_if #(
    parameter int LEN_W = 5
);
    logic             rx_empty;
    logic [7:0]       r_data;
    logic             rd_uart;
    logic [7:0]       pkt_data;
    logic             pkt_valid;
    logic             pkt_ready;
    logic             pkt_last;
    logic [LEN_W-1:0] pkt_len;
    logic             frame_ok;
    logic             len_err;
    logic             chk_err;
    logic             to_err;

    modport master (
        input  rx_empty, r_data, pkt_ready,
        output rd_uart, pkt_data, pkt_valid, pkt_last, pkt_len,
               frame_ok, len_err, chk_err, to_err
    );

    modport slave (
        output rx_empty, r_data, pkt_ready,
        input  rd_uart, pkt_data, pkt_valid, pkt_last, pkt_len,
               frame_ok, len_err, chk_err, to_err
    );
endinterface

// File: rtl/uart_pkt_buf.sv
// rtl/uart_pkt_buf.sv - payload register file, sync write, async read
module uart_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [7:0]       rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_pkt_rx.sv
// rtl/uart_pkt_rx.sv - sync hunt, length/checksum validation and release of UART packets
module uart_pkt_rx
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
    parameter int         MAX_LEN   = 16,
    parameter int         TO_CYC    = 65536
) (
    input logic           clk,
    input logic           rst,
    uart_pkt_rx_if.master bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TO_W  = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx, out_idx;
    logic [LEN_W-1:0]   pkt_len_q;
    logic [CHK_W-1:0]   acc;
    logic [CHK_W-1:0]   sum;
    logic [TO_W-1:0]    to_cnt;
    logic               frame_ok_q, len_err_q, chk_err_q;
    logic               pop, in_frame, expire, xfer;
    logic               len_ok, last_in, last_out;
    logic [7:0]         buf_rdata;

    // Popping stops in SEND so the next frame waits in the UART FIFO.
    assign pop      = !rst && !bus.rx_empty && (state != ST_SEND);
    assign in_frame = (state == ST_LEN) || (state == ST_PAY) || (state == ST_CHK);
    assign expire   = in_frame && !pop && (to_cnt == TO_LAST);
    assign xfer     = (state == ST_SEND) && bus.pkt_ready;
    assign sum      = acc + bus.r_data;
    assign len_ok   = (bus.r_data != 8'd0) && (int'(bus.r_data) <= MAX_LEN);
    assign last_in  = (LEN_W'(idx) == pkt_len_q - LEN_W'(1));
    assign last_out = (LEN_W'(out_idx) == pkt_len_q - LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_HUNT;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_HUNT: if (pop && bus.r_data == SYNC_BYTE) state_d = ST_LEN;
            ST_LEN: begin
                if (pop)         state_d = len_ok ? ST_PAY : ST_HUNT;
                else if (expire) state_d = ST_HUNT;
            end
            ST_PAY: begin
                if (pop && last_in) state_d = ST_CHK;
                else if (expire)    state_d = ST_HUNT;
            end
            ST_CHK: begin
                if (pop)         state_d = (sum == '0) ? ST_SEND : ST_HUNT;
                else if (expire) state_d = ST_HUNT;
            end
            ST_SEND: if (xfer && last_out) state_d = ST_HUNT;
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            out_idx    <= '0;
            pkt_len_q  <= '0;
            acc        <= '0;
            to_cnt     <= '0;
            frame_ok_q <= 1'b0;
            len_err_q  <= 1'b0;
            chk_err_q  <= 1'b0;
        end else begin
            frame_ok_q <= (state == ST_CHK) && pop && (sum == '0);
            chk_err_q  <= (state == ST_CHK) && pop && (sum != '0);
            len_err_q  <= (state == ST_LEN) && pop && !len_ok;

            if (!in_frame || pop || expire) to_cnt <= '0;
            else                            to_cnt <= to_cnt + 1'b1;

            if (state == ST_LEN && pop && len_ok) begin
                pkt_len_q <= bus.r_data[LEN_W-1:0];
                acc       <= bus.r_data;
                idx       <= '0;
            end
            if (state == ST_PAY && pop) begin
                acc <= sum;
                idx <= idx + 1'b1;
            end
            if (state == ST_CHK && pop) out_idx <= '0;
            if (xfer) out_idx <= last_out ? '0 : out_idx + 1'b1;
        end
    end

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk   (clk),
        .we    (state == ST_PAY && pop),
        .waddr (idx),
        .wdata (bus.r_data),
        .raddr (out_idx),
        .rdata (buf_rdata)
    );

    assign bus.rd_uart   = pop;
    assign bus.pkt_valid = (state == ST_SEND);
    assign bus.pkt_data  = (state == ST_SEND) ? buf_rdata : 8'h00;
    assign bus.pkt_last  = (state == ST_SEND) && last_out;
    assign bus.pkt_len   = pkt_len_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.len_err   = len_err_q;
    assign bus.chk_err   = chk_err_q;
    assign bus.to_err    = expire;
endmodule

// File: tb/tb_uart_pkt_rx.sv
// tb/tb_uart_pkt_rx.sv - directed self-checking bench for uart_pkt_rx
module tb_uart_pkt_rx;
    logic clk = 1'b0;
    logic rst;
    logic ready;

    always #5 clk = ~clk;

    uart_pkt_rx_if #(.LEN_W(5)) bus ();

    uart_pkt_rx #(
        .SYNC_BYTE (8'hA5),
        .MAX_LEN   (16),
        .TO_CYC    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] fifo[$];
    logic [7:0] got[$];
    logic       got_last[$];
    int cyc, n_ok, n_len, n_chk, n_to, ok_cyc, to_cyc, first_valid_cyc;
    int last_pop_cyc, last_xfer_cyc, resume_cyc, n_rd_in_send, pop_cyc;
    logic [4:0] seen_len;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic drive_inputs();
        bus.rx_empty  = (fifo.size() == 0);
        bus.r_data    = (fifo.size() != 0) ? fifo[0] : 8'h00;
        bus.pkt_ready = ready;
    endtask

    task automatic clear_stats();
        got.delete();
        got_last.delete();
        n_ok = 0; n_len = 0; n_chk = 0; n_to = 0;
        ok_cyc = -1; to_cyc = -1; first_valid_cyc = -1;
        last_pop_cyc = -1; last_xfer_cyc = -1; resume_cyc = -1;
        n_rd_in_send = 0; seen_len = '0;
    endtask

    // One clock: present FIFO head at negedge, observe, and mirror the pop the DUT will take.
    task automatic cycle();
        @(negedge clk);
        drive_inputs();
        #1;
        cyc++;
        if (bus.frame_ok) begin n_ok++; ok_cyc = cyc; end
        if (bus.len_err) n_len++;
        if (bus.chk_err) n_chk++;
        if (bus.to_err) begin n_to++; to_cyc = cyc; end
        if (bus.pkt_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            seen_len = bus.pkt_len;
            if (bus.rd_uart) n_rd_in_send++;
            if (ready) begin
                got.push_back(bus.pkt_data);
                got_last.push_back(bus.pkt_last);
                if (bus.pkt_last && last_xfer_cyc < 0) last_xfer_cyc = cyc;
            end
        end
        if (bus.rd_uart) begin
            if (last_xfer_cyc >= 0 && resume_cyc < 0) resume_cyc = cyc;
            last_pop_cyc = cyc;
            void'(fifo.pop_front());
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_until_drained();
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (fifo.size() == 0) break;
        end
    endtask

    task automatic run_until_valid();
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (bus.pkt_valid) break;
        end
    endtask

    function automatic logic [31:0] pack_bytes();
        logic [31:0] w = '0;
        foreach (got[i]) w = (w << 8) | 32'(got[i]);
        return w;
    endfunction

    function automatic logic [31:0] pack_last();
        logic [31:0] w = '0;
        foreach (got_last[i]) w = (w << 1) | 32'(got_last[i]);
        return w;
    endfunction

    task automatic push_good3();
        fifo.push_back(8'hA5); fifo.push_back(8'h03); fifo.push_back(8'h11);
        fifo.push_back(8'h22); fifo.push_back(8'h33); fifo.push_back(8'h97);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cyc = 0;
        ready = 1'b1;
        rst = 1'b1;
        clear_stats();
        fifo.push_back(8'hA5);
        drive_inputs();
        #2;
        check_eq("rst rd_uart", bus.rd_uart, 0);
        check_eq("rst pkt_valid", bus.pkt_valid, 0);
        check_eq("rst pkt_data", bus.pkt_data, 0);
        check_eq("rst pkt_len", bus.pkt_len, 0);
        check_eq("rst pulses", {bus.pkt_last, bus.frame_ok, bus.len_err, bus.chk_err, bus.to_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fifo.delete();
        drive_inputs();

        // good frame
        clear_stats();
        push_good3();
        run(15);
        check_eq("good frame_ok", n_ok, 1);
        check_eq("good pkt_len", seen_len, 3);
        check_eq("good count", got.size(), 3);
        check_eq("good data", pack_bytes(), 32'h00112233);
        check_eq("good last", pack_last(), 32'b001);
        check_eq("good latency", first_valid_cyc - last_pop_cyc, 1);
        check_eq("good ok with valid", ok_cyc, first_valid_cyc);
        check_eq("good no errs", n_len + n_chk + n_to, 0);

        // bad checksum then good frame
        clear_stats();
        fifo.push_back(8'hA5); fifo.push_back(8'h03); fifo.push_back(8'h11);
        fifo.push_back(8'h22); fifo.push_back(8'h33); fifo.push_back(8'h98);
        fifo.push_back(8'hA5); fifo.push_back(8'h03); fifo.push_back(8'h44);
        fifo.push_back(8'h55); fifo.push_back(8'h66); fifo.push_back(8'hFE);
        run(25);
        check_eq("chk chk_err", n_chk, 1);
        check_eq("chk frame_ok", n_ok, 1);
        check_eq("chk data", pack_bytes(), 32'h00445566);
        check_eq("chk last", pack_last(), 32'b001);

        // garbage and length errors then good frame
        clear_stats();
        fifo.push_back(8'h00); fifo.push_back(8'hFF); fifo.push_back(8'h5A);
        fifo.push_back(8'hA5); fifo.push_back(8'h00);
        fifo.push_back(8'hA5); fifo.push_back(8'h11);
        fifo.push_back(8'hA5); fifo.push_back(8'h02); fifo.push_back(8'hAA);
        fifo.push_back(8'hBB); fifo.push_back(8'h99);
        run(30);
        check_eq("len len_err", n_len, 2);
        check_eq("len frame_ok", n_ok, 1);
        check_eq("len chk_err", n_chk, 0);
        check_eq("len data", pack_bytes(), 32'h0000AABB);
        check_eq("len last", pack_last(), 32'b01);

        // timeout mid-PAY
        clear_stats();
        fifo.push_back(8'hA5); fifo.push_back(8'h02); fifo.push_back(8'h11);
        run_until_drained();
        pop_cyc = last_pop_cyc;
        run(12);
        check_eq("to count", n_to, 1);
        check_eq("to delay", to_cyc - pop_cyc, 8);
        check_eq("to no stream", got.size(), 0);
        clear_stats();
        fifo.push_back(8'h11);
        fifo.push_back(8'hA5); fifo.push_back(8'h01); fifo.push_back(8'h7E);
        fifo.push_back(8'h81);
        run(15);
        check_eq("to next ok", n_ok, 1);
        check_eq("to next data", pack_bytes(), 32'h0000007E);
        check_eq("to next errs", n_len + n_chk + n_to, 0);

        // byte arriving in the expiring cycle wins
        clear_stats();
        fifo.push_back(8'hA5); fifo.push_back(8'h02); fifo.push_back(8'h11);
        run_until_drained();
        run(7);
        fifo.push_back(8'h22);
        cycle();
        fifo.push_back(8'hCB);
        run(10);
        check_eq("edge to_err", n_to, 0);
        check_eq("edge frame_ok", n_ok, 1);
        check_eq("edge data", pack_bytes(), 32'h00001122);

        // backpressure in SEND with the next frame already queued
        clear_stats();
        ready = 1'b0;
        push_good3();
        fifo.push_back(8'hA5); fifo.push_back(8'h01); fifo.push_back(8'h7E);
        fifo.push_back(8'h81);
        run_until_valid();
        check_eq("bp valid", bus.pkt_valid, 1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("bp rd_uart", bus.rd_uart, 0);
            check_eq("bp data", bus.pkt_data, 8'h11);
            check_eq("bp valid hold", bus.pkt_valid, 1);
            check_eq("bp last", bus.pkt_last, 0);
        end
        check_eq("bp fifo held", fifo.size(), 4);
        ready = 1'b1;
        run(20);
        check_eq("bp data", pack_bytes(), 32'h1122337E);
        check_eq("bp last flags", pack_last(), 32'b0011);
        check_eq("bp frame_ok", n_ok, 2);
        check_eq("bp rd in send", n_rd_in_send, 0);
        check_eq("bp resume", resume_cyc - last_xfer_cyc, 1);

        // reset mid-PAY
        clear_stats();
        fifo.push_back(8'hA5); fifo.push_back(8'h04); fifo.push_back(8'h01);
        fifo.push_back(8'h02);
        run_until_drained();
        fifo.push_back(8'h55);
        drive_inputs();
        #2;
        rst = 1'b1;
        #1;
        check_eq("rpay rd_uart", bus.rd_uart, 0);
        check_eq("rpay pkt_len", bus.pkt_len, 0);
        check_eq("rpay outs", {bus.pkt_valid, bus.pkt_last, bus.frame_ok, bus.len_err, bus.chk_err, bus.to_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fifo.delete();
        drive_inputs();
        clear_stats();
        push_good3();
        run(15);
        check_eq("rpay frame_ok", n_ok, 1);
        check_eq("rpay data", pack_bytes(), 32'h00112233);
        check_eq("rpay errs", n_len + n_chk + n_to, 0);

        // reset mid-SEND
        clear_stats();
        ready = 1'b0;
        push_good3();
        run_until_valid();
        check_eq("rsend valid", bus.pkt_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rsend pkt_data", bus.pkt_data, 0);
        check_eq("rsend pkt_len", bus.pkt_len, 0);
        check_eq("rsend outs", {bus.pkt_valid, bus.pkt_last, bus.rd_uart, bus.frame_ok, bus.len_err, bus.chk_err, bus.to_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        fifo.delete();
        drive_inputs();
        clear_stats();
        fifo.push_back(8'hA5); fifo.push_back(8'h02); fifo.push_back(8'hAA);
        fifo.push_back(8'hBB); fifo.push_back(8'h99);
        run(15);
        check_eq("rsend frame_ok", n_ok, 1);
        check_eq("rsend data", pack_bytes(), 32'h0000AABB);
        check_eq("rsend errs", n_len + n_chk + n_to, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
